// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//  Runs one complete 8-bit register read or write on a 7-bit I2C slave by
//  stepping the byte-level I2C master driver through open, address, register,
//  optional repeated start, data and stop. ACKs are checked after each written
//  byte, and every driver step is bounded by TIMEOUT_CYCLES.
//  Optional feature macro: I2C_SEQ_RETRY_EN. When it is defined, a NACKed
//  request is restarted from OPEN up to MAX_RETRY more times.
module i2c_reg_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000,
   parameter int unsigned MAX_RETRY      = 32'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       req_rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   output logic       seq_busy,
   output logic       done,
   output logic       err,
   output logic [7:0] rd_data,
   output logic       drv_ena,
   output logic       drv_start_transfer,
   output logic       drv_stop_transfer,
   output logic       drv_r_start,
   output logic       drv_rw,
   output logic [7:0] drv_data_wr,
   input  logic [7:0] drv_data_rd,
   input  logic       drv_busy,
   input  logic       drv_ready,
   input  logic       drv_ack_err
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_OPEN   = 4'd1,
      S_ADDR_W = 4'd2,
      S_REG    = 4'd3,
      S_DATA   = 4'd4,
      S_RSTART = 4'd5,
      S_ADDR_R = 4'd6,
      S_READ   = 4'd7,
      S_STOP   = 4'd8,
      S_DONE   = 4'd9
   } state_t;

   // A value of 0 disables the step timeout entirely.
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

   state_t      state_q, state_d;
   logic        acc_q, acc_d;        // driver has accepted the current step
   logic [31:0] cnt_q, cnt_d;        // cycles spent in the current step
   logic        rw_q, rw_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  reg_q, reg_d;
   logic [7:0]  wdat_q, wdat_d;
   logic [7:0]  rbuf_q, rbuf_d;      // read byte awaiting a clean finish
   logic        nack_q, nack_d;
   logic        tmo_q, tmo_d;
   logic        active_s;
`ifdef I2C_SEQ_RETRY_EN
   logic [31:0] retry_q, retry_d;
`endif

   logic        seq_busy_q, seq_busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        drv_ena_q, drv_ena_d;
   logic        drv_start_q, drv_start_d;
   logic        drv_stop_q, drv_stop_d;
   logic        drv_r_start_q, drv_r_start_d;
   logic        drv_rw_q, drv_rw_d;
   logic [7:0]  drv_data_wr_q, drv_data_wr_d;

   // Next state: request latch, per-step strobe/accept/complete handshake, ACK check and timeout abort
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = 32'd0;
      rw_d     = rw_q;
      dev_d    = dev_q;
      reg_d    = reg_q;
      wdat_d   = wdat_q;
      rbuf_d   = rbuf_q;
      nack_d   = nack_q;
      tmo_d    = tmo_q;
      active_s = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef I2C_SEQ_RETRY_EN
      retry_d  = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_OPEN;
               rw_d    = req_rw;
               dev_d   = dev_addr;
               reg_d   = reg_addr;
               wdat_d  = wr_data;
               nack_d  = 1'b0;
               tmo_d   = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
               retry_d = 32'd0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_OPEN, S_RSTART: begin
            if (!acc_q) begin
               acc_d = drv_busy;
            end else if (drv_ready) begin
               state_d = (state_q == S_OPEN) ? S_ADDR_W : S_ADDR_R;
            end else begin
               state_d = state_q;
            end
         end
         S_ADDR_W, S_REG, S_DATA, S_ADDR_R: begin
            if (!acc_q) begin
               acc_d = drv_busy;
            end else if (drv_ready) begin
               if (drv_ack_err) begin
                  // Slave refused the byte: skip the rest and close the bus
                  state_d = S_STOP;
                  nack_d  = 1'b1;
               end else begin
                  case (state_q)
                     S_ADDR_W: state_d = S_REG;
                     S_REG:    state_d = rw_q ? S_RSTART : S_DATA;
                     S_ADDR_R: state_d = S_READ;
                     default:  state_d = S_STOP;
                  endcase
               end
            end else begin
               state_d = state_q;
            end
         end
         S_READ: begin
            if (!acc_q) begin
               acc_d = drv_busy;
            end else if (drv_ready) begin
               rbuf_d  = drv_data_rd;
               state_d = S_STOP;
            end else begin
               state_d = S_READ;
            end
         end
         S_STOP: begin
            if (!acc_q) begin
               acc_d = drv_busy;
            end else if (drv_ready && !drv_busy) begin
`ifdef I2C_SEQ_RETRY_EN
               if (nack_q && (retry_q < MAX_RETRY)) begin
                  state_d = S_OPEN;
                  nack_d  = 1'b0;
                  retry_d = retry_q + 32'd1;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_STOP;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A stalled step abandons the request outright; it is never retried
      if (TMO_EN && active_s && (cnt_q == TMO_LAST)) begin
         state_d = S_DONE;
         tmo_d   = 1'b1;
      end else begin
         tmo_d   = tmo_d;
      end

      if (state_d != state_q) begin
         acc_d = 1'b0;
         cnt_d = 32'd0;
      end else if (active_s) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = 32'd0;
      end
   end

   // Output decode from the upcoming state so every port comes straight from a flop
   always_comb begin
      seq_busy_d    = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
      err_d         = done_d && (nack_d || tmo_d);
      drv_ena_d     = (state_d != S_IDLE) && (state_d != S_STOP) && (state_d != S_DONE);
      drv_start_d   = !acc_d && ((state_d == S_ADDR_W) || (state_d == S_REG) || (state_d == S_DATA) ||
                                 (state_d == S_ADDR_R) || (state_d == S_READ));
      drv_stop_d    = !acc_d && (state_d == S_STOP);
      drv_r_start_d = !acc_d && (state_d == S_RSTART);
      drv_rw_d      = (state_d == S_READ);
      case (state_d)
         S_ADDR_W: drv_data_wr_d = {dev_d, 1'b0};
         S_REG:    drv_data_wr_d = reg_d;
         S_DATA:   drv_data_wr_d = wdat_d;
         S_ADDR_R: drv_data_wr_d = {dev_d, 1'b1};
         default:  drv_data_wr_d = 8'h00;
      endcase
      if (done_d && rw_d && !nack_d && !tmo_d) begin
         rd_data_d = rbuf_d;
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // State, request context and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         acc_q         <= 1'b0;
         cnt_q         <= 32'd0;
         rw_q          <= 1'b0;
         dev_q         <= 7'h00;
         reg_q         <= 8'h00;
         wdat_q        <= 8'h00;
         rbuf_q        <= 8'h00;
         nack_q        <= 1'b0;
         tmo_q         <= 1'b0;
         seq_busy_q    <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         rd_data_q     <= 8'h00;
         drv_ena_q     <= 1'b0;
         drv_start_q   <= 1'b0;
         drv_stop_q    <= 1'b0;
         drv_r_start_q <= 1'b0;
         drv_rw_q      <= 1'b0;
         drv_data_wr_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         rw_q          <= rw_d;
         dev_q         <= dev_d;
         reg_q         <= reg_d;
         wdat_q        <= wdat_d;
         rbuf_q        <= rbuf_d;
         nack_q        <= nack_d;
         tmo_q         <= tmo_d;
         seq_busy_q    <= seq_busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         rd_data_q     <= rd_data_d;
         drv_ena_q     <= drv_ena_d;
         drv_start_q   <= drv_start_d;
         drv_stop_q    <= drv_stop_d;
         drv_r_start_q <= drv_r_start_d;
         drv_rw_q      <= drv_rw_d;
         drv_data_wr_q <= drv_data_wr_d;
      end
   end

`ifdef I2C_SEQ_RETRY_EN
   // Number of restarts already spent on the current request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retry_q <= 32'd0;
      end else begin
         retry_q <= retry_d;
      end
   end
`endif

   assign seq_busy           = seq_busy_q;
   assign done               = done_q;
   assign err                = err_q;
   assign rd_data            = rd_data_q;
   assign drv_ena            = drv_ena_q;
   assign drv_start_transfer = drv_start_q;
   assign drv_stop_transfer  = drv_stop_q;
   assign drv_r_start        = drv_r_start_q;
   assign drv_rw             = drv_rw_q;
   assign drv_data_wr        = drv_data_wr_q;

endmodule
